// File: rtl/mem_subsystem_rr_pkg.sv
// Shared types and helpers for the round-robin shared-memory subsystem.
package mem_subsystem_pkg;

    typedef enum logic [1:0] {
        COH_I = 2'b00,
        COH_M = 2'b01,
        COH_S = 2'b10
    } coherency_t;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_ACCESS
    } fsm_t;

    // Value written to entry idx by the post-reset init sweep.
    function automatic int unsigned init_value(input int unsigned idx);
        return idx + 1;
    endfunction

endpackage

// File: rtl/mem_subsystem_rr_if.sv
// Requester-side bundle of the shared-memory subsystem: packed per-port request
// fields towards the memory, shared response fields back.
interface mem_subsystem_rr_if #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 14
) ();
    import mem_subsystem_pkg::*;

    logic [NUM_PORTS-1:0]        req;
    logic [NUM_PORTS-1:0]        we;
    logic [NUM_PORTS*ADDR_W-1:0] addr;
    logic [NUM_PORTS*DATA_W-1:0] wdata;
    logic [NUM_PORTS-1:0]        resp;
    logic [DATA_W-1:0]           rdata;
    logic                        err;
    coherency_t                  coh_state;
    logic                        busy;

    modport master (
        output req, we, addr, wdata,
        input  resp, rdata, err, coh_state, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output resp, rdata, err, coh_state, busy
    );

endinterface

// File: rtl/mem_subsystem_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the rotating
// pointer; the pointer moves past the winner only when the grant is taken.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id
);
    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr;
    int unsigned   cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        cand        = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = (32'(ptr) + i) % N;
            if (!grant_valid && req[cand[PW-1:0]]) begin
                grant_valid = 1'b1;
                grant_id    = cand[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_id == PW'(N - 1)) ? '0 : grant_id + PW'(1);
        end
    end

endmodule

// File: rtl/mem_subsystem_rr.sv
// Shared memory for NUM_PORTS requesters: round-robin arbitration, fixed-latency
// registered response, per-entry I/S/M coherency with owner, init sweep after reset.
module mem_subsystem_rr
    import mem_subsystem_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 14,
    parameter int DEPTH     = 50
) (
    input  logic             clk,
    input  logic             reset_n,
    mem_subsystem_rr_if.slave bus
);
    localparam int PORT_W = $clog2(NUM_PORTS);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

    fsm_t                 state;
    logic [IDX_W-1:0]     init_cnt;
    logic [PORT_W-1:0]    lat_port;
    logic                 lat_we;
    logic [ADDR_W-1:0]    lat_addr;
    logic [DATA_W-1:0]    lat_wdata;

    logic [NUM_PORTS-1:0] resp_q;
    logic [DATA_W-1:0]    rdata_q;
    logic                 err_q;
    coherency_t           coh_out_q;

    logic [DATA_W-1:0]    mem_arr   [DEPTH];
    coherency_t           coh_arr   [DEPTH];
    logic [PORT_W-1:0]    owner_arr [DEPTH];

    logic [NUM_PORTS-1:0] eligible;
    logic                 grant_valid;
    logic [PORT_W-1:0]    grant_id;
    logic                 advance;

    logic [IDX_W-1:0]     acc_idx;
    logic                 in_range;
    coherency_t           cur_coh;
    logic [PORT_W-1:0]    cur_owner;
    coherency_t           nxt_coh;
    logic [PORT_W-1:0]    nxt_owner;
    logic [DATA_W-1:0]    acc_rdata;

    logic                 wr_en;
    logic                 wr_data_en;
    logic [IDX_W-1:0]     wr_idx;
    logic [DATA_W-1:0]    wr_data;
    coherency_t           wr_coh;
    logic [PORT_W-1:0]    wr_owner;

    // A port still showing its resp pulse has already been served this round.
    assign eligible = bus.req & ~resp_q;
    assign advance  = (state == ST_IDLE) && grant_valid;

    rr_arbiter #(.N(NUM_PORTS)) u_arb (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (eligible),
        .advance    (advance),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    always_comb begin
        acc_idx   = lat_addr[IDX_W-1:0];
        in_range  = ({1'b0, lat_addr} < DEPTH_A);
        cur_coh   = coh_arr[acc_idx];
        cur_owner = owner_arr[acc_idx];
        nxt_coh   = cur_coh;
        nxt_owner = cur_owner;
        acc_rdata = mem_arr[acc_idx];

        if (lat_we) begin
            nxt_coh   = COH_M;
            nxt_owner = lat_port;
            acc_rdata = lat_wdata;
        end else begin
            case (cur_coh)
                COH_I:   nxt_coh = COH_S;
                COH_M:   if (cur_owner != lat_port) nxt_coh = COH_S;
                default: nxt_coh = cur_coh;
            endcase
        end

        if (!in_range) begin
            acc_rdata = '0;
            nxt_coh   = COH_I;
        end

        wr_en      = 1'b0;
        wr_data_en = 1'b0;
        wr_idx     = acc_idx;
        wr_data    = lat_wdata;
        wr_coh     = nxt_coh;
        wr_owner   = nxt_owner;
        case (state)
            ST_INIT: begin
                wr_en      = 1'b1;
                wr_data_en = 1'b1;
                wr_idx     = init_cnt;
                wr_data    = DATA_W'(init_value(32'(init_cnt)));
                wr_coh     = COH_I;
                wr_owner   = '0;
            end
            ST_ACCESS: begin
                wr_en      = in_range;
                wr_data_en = in_range && lat_we;
            end
            default: ;
        endcase
    end

    // Array update is gated by reset_n so a reset in the ACCESS cycle leaves storage untouched.
    always_ff @(posedge clk) begin
        if (reset_n && wr_en) begin
            coh_arr[wr_idx]   <= wr_coh;
            owner_arr[wr_idx] <= wr_owner;
            if (wr_data_en) mem_arr[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            lat_port  <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            resp_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            coh_out_q <= COH_I;
        end else begin
            resp_q <= '0;
            case (state)
                ST_INIT: begin
                    if (init_cnt == IDX_W'(DEPTH - 1)) state <= ST_IDLE;
                    else init_cnt <= init_cnt + IDX_W'(1);
                end
                ST_IDLE: begin
                    if (grant_valid) begin
                        lat_port  <= grant_id;
                        lat_we    <= bus.we[grant_id];
                        lat_addr  <= bus.addr[grant_id*ADDR_W +: ADDR_W];
                        lat_wdata <= bus.wdata[grant_id*DATA_W +: DATA_W];
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    resp_q    <= NUM_PORTS'(1) << lat_port;
                    rdata_q   <= acc_rdata;
                    err_q     <= !in_range;
                    coh_out_q <= nxt_coh;
                    state     <= ST_IDLE;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    assign bus.resp      = resp_q;
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;
    assign bus.coh_state = coh_out_q;
    assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_subsystem_rr.sv
// Bench for mem_subsystem_rr: directed scenarios plus random traffic checked
// against an array-based model of the memory, coherency rules and rotation order.
module tb_mem_subsystem_rr;
    localparam int NP    = 4;
    localparam int DW    = 16;
    localparam int AW    = 14;
    localparam int DEPTH = 50;
    localparam int C_I   = 0;
    localparam int C_M   = 1;
    localparam int C_S   = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_subsystem_rr_if #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW)) bus ();

    mem_subsystem_rr #(
        .NUM_PORTS(NP),
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .DEPTH    (DEPTH)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int unsigned m_mem   [DEPTH];
    int          m_coh   [DEPTH];
    int          m_owner [DEPTH];
    int          m_ptr;

    bit          op_we    [NP];
    int unsigned op_addr  [NP];
    int unsigned op_wdata [NP];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]   = (i + 1) & 32'hFFFF;
            m_coh[i]   = C_I;
            m_owner[i] = 0;
        end
        m_ptr = 0;
    endtask

    task automatic model_access(input int p, input bit we, input int unsigned a,
                                input int unsigned wd, output int unsigned rd,
                                output int er, output int coh);
        if (a >= DEPTH) begin
            rd = 0; er = 1; coh = C_I;
            return;
        end
        er = 0;
        if (we) begin
            m_mem[a]   = wd;
            m_coh[a]   = C_M;
            m_owner[a] = p;
            rd = wd;
        end else begin
            rd = m_mem[a];
            if (m_coh[a] == C_I) m_coh[a] = C_S;
            else if (m_coh[a] == C_M && m_owner[a] != p) m_coh[a] = C_S;
        end
        coh = m_coh[a];
    endtask

    task automatic set_op(input int p, input bit we, input int unsigned a, input int unsigned wd);
        op_we[p] = we; op_addr[p] = a; op_wdata[p] = wd;
        bus.we[p]              = we;
        bus.addr[p*AW +: AW]   = a[AW-1:0];
        bus.wdata[p*DW +: DW]  = wd[DW-1:0];
    endtask

    // Raise the masked requests together; expected service order is the rotation from m_ptr.
    task automatic burst(input logic [NP-1:0] mask, input bit rereq0);
        int q[$];
        int cyc = 0;
        int last = 0;
        bit pend = 0;
        bit rdone = 0;
        int p, ep, er, coh;
        int unsigned rd;
        for (int k = 0; k < NP; k++)
            if (mask[(m_ptr + k) % NP]) q.push_back((m_ptr + k) % NP);
        for (int i = 0; i < NP; i++)
            if (mask[i]) bus.req[i] = 1'b1;
        while (q.size() > 0 && cyc < 8*NP + 8) begin
            @(negedge clk);
            cyc++;
            if (pend) begin bus.req[0] = 1'b1; pend = 0; end
            if (bus.resp != '0) begin
                p = -1;
                for (int i = 0; i < NP; i++) if (bus.resp[i] && p < 0) p = i;
                ep = q.pop_front();
                chk("resp_onehot", $countones(bus.resp), 1);
                chk("grant_order", p, ep);
                chk("resp_spacing", cyc - last, 2);
                last = cyc;
                m_ptr = (ep + 1) % NP;
                model_access(p, op_we[p], op_addr[p], op_wdata[p], rd, er, coh);
                chk("rdata", bus.rdata, rd);
                chk("err", bus.err, er);
                chk("coh_state", bus.coh_state, coh);
                bus.req[p] = 1'b0;
                if (rereq0 && p == 0 && !rdone) begin
                    rdone = 1; pend = 1; q.push_back(0);
                end
            end
        end
        chk("burst_complete", q.size(), 0);
        bus.req = '0;
        @(negedge clk);
        chk("resp_single_pulse", bus.resp, 0);
    endtask

    task automatic single(input int p, input bit we, input int unsigned a, input int unsigned wd);
        set_op(p, we, a, wd);
        burst(NP'(1) << p, 1'b0);
    endtask

    task automatic wait_init();
        int cnt = 0;
        while (bus.busy === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        chk("init_busy_cycles", cnt, DEPTH);
        model_init();
    endtask

    initial begin
        logic [NP-1:0] mask;
        int unsigned   a;
        bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
        model_init();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_resp", bus.resp, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_coh", bus.coh_state, C_I);
        chk("rst_busy", bus.busy, 1);
        reset_n = 1'b1;
        wait_init();

        // Fairness from first IDLE cycle; also covers post-init reads of 0, 7, 49
        set_op(0, 1'b0, 0, 0);
        set_op(1, 1'b0, 7, 0);
        set_op(2, 1'b0, 49, 0);
        set_op(3, 1'b0, 20, 0);
        burst(4'b1111, 1'b1);

        // Write/read same port, then downgrade by another reader
        single(2, 1'b1, 5, 32'hBEEF);
        single(2, 1'b0, 5, 0);
        single(0, 1'b0, 5, 0);
        chk("downgrade_data", m_mem[5], 32'hBEEF);

        // Out of range
        single(1, 1'b0, 50, 0);
        single(1, 1'b1, 32'h3FFF, 32'h5A5A);
        single(1, 1'b0, 49, 0);
        chk("idle_busy", bus.busy, 0);

        // Random single accesses and bursts
        for (int n = 0; n < 40; n++) begin
            mask = (n < 25) ? (NP'(1) << $urandom_range(0, NP-1)) : NP'($urandom_range(1, (1 << NP) - 1));
            for (int p = 0; p < NP; p++) begin
                a = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, 16383) : $urandom_range(0, DEPTH-1);
                set_op(p, 1'($urandom_range(0, 1)), a, $urandom_range(0, 65535));
            end
            burst(mask, 1'b0);
        end

        // Reset during the ACCESS cycle of a write
        set_op(1, 1'b1, 3, 32'h1234);
        bus.req[1] = 1'b1;
        @(negedge clk);
        chk("midop_busy", bus.busy, 1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midop_resp_a", bus.resp, 0);
        bus.req = '0;
        @(negedge clk);
        chk("midop_resp_b", bus.resp, 0);
        reset_n = 1'b1;
        wait_init();
        single(1, 1'b0, 3, 0);
        chk("midop_reinit_model", m_mem[3], 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
